// File: rtl/gray_pos_tracker.sv
// gray_pos_tracker
//   Debounces a raw 4-bit Gray encoder bus and decodes each newly stable code
//   with one converter instance. Each legal code becomes a position event on
//   a valid/ready handshake. A code is flagged as a skip when its position
//   differs from the previous one by more than 1. Illegal codes and skips are
//   counted. Repeated illegal codes latch a fault, which clr releases.
//
//   Parameters
//     STABLE_CYCLES  consecutive identical samples before evaluation (>=1)
//     ERR_LIMIT      consecutive illegal codes that force FAULT (1..15)
//   Ports
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     en         tracking enable
//     clr        one-cycle pulse: clear error counters, leave FAULT
//     nin        raw Gray code from encoder
//     out_ready  consumer accepts the pending event
//     out_valid  event available (HOLD)
//     pos_out    decoded position 0..8
//     dir        1 = position increased, 0 = decreased or first event
//     skip       |delta| > 1 versus previous position
//     err_cnt    saturating count of illegal codes plus skips
//     fault      FAULT state indicator

// converter
//   Decodes a 4-bit Gray code to a position 0..8. Any code outside the
//   legal set decodes to 0 with sgn=1.
//   Ports: nin (code in), nout (position out), sgn (illegal code flag)
module converter (
    input  logic [3:0] nin,
    output logic [3:0] nout,
    output logic       sgn
);
    always_comb begin
        nout = '0;
        sgn  = 1'b0;
        case (nin)
            4'b0000: nout = 4'd0;
            4'b0001: nout = 4'd1;
            4'b0011: nout = 4'd2;
            4'b0010: nout = 4'd3;
            4'b0110: nout = 4'd4;
            4'b0111: nout = 4'd5;
            4'b0101: nout = 4'd6;
            4'b0100: nout = 4'd7;
            4'b1100: nout = 4'd8;
            default: sgn  = 1'b1;
        endcase
    end
endmodule

module gray_pos_tracker #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_LIMIT     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] nin,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] pos_out,
    output logic       dir,
    output logic       skip,
    output logic [3:0] err_cnt,
    output logic       fault
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [4:0]    LIMIT   = 5'(ERR_LIMIT);

    typedef enum logic [2:0] {IDLE, SETTLE, EVAL, HOLD, FAULT} state_t;

    state_t          state;
    logic [3:0]      nin_q;
    logic [CW-1:0]   cnt;
    logic            stable;
    logic [3:0]      last_code;
    logic            last_vld;
    logic            have_ref;
    logic [3:0]      pos;
    logic [3:0]      consec;

    logic [3:0]        conv_nout;
    logic              conv_sgn;
    logic signed [4:0] diff;
    logic              is_skip;
    logic [3:0]        err_sat;
    logic [4:0]        consec_inc;

    converter u_conv (
        .nin  (nin_q),
        .nout (conv_nout),
        .sgn  (conv_sgn)
    );

    assign stable     = (cnt == CNT_MAX);
    assign diff       = signed'({1'b0, conv_nout}) - signed'({1'b0, pos});
    assign is_skip    = (diff > 5'sd1) || (diff < -5'sd1);
    assign err_sat    = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
    assign consec_inc = {1'b0, consec} + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            nin_q     <= '0;
            cnt       <= '0;
            last_code <= '0;
            last_vld  <= 1'b0;
            have_ref  <= 1'b0;
            pos       <= '0;
            consec    <= '0;
            out_valid <= 1'b0;
            pos_out   <= '0;
            dir       <= 1'b0;
            skip      <= 1'b0;
            err_cnt   <= '0;
            fault     <= 1'b0;
        end else begin
            // Debounce runs in every state, including HOLD and FAULT.
            nin_q <= nin;
            if (nin == nin_q)
                cnt <= stable ? cnt : cnt + CW'(1);
            else
                cnt <= '0;

            case (state)
                IDLE: begin
                    if (en)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (!en)
                        state <= IDLE;
                    else if (stable && (!last_vld || nin_q != last_code))
                        state <= EVAL;
                end
                EVAL: begin
                    last_code <= nin_q;
                    last_vld  <= 1'b1;
                    if (conv_sgn) begin
                        err_cnt <= err_sat;
                        consec  <= consec_inc[3:0];
                        // A concurrent clr empties the counters, so the
                        // limit is never considered reached.
                        if (consec_inc == LIMIT && !clr) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end else begin
                        pos       <= conv_nout;
                        pos_out   <= conv_nout;
                        have_ref  <= 1'b1;
                        consec    <= '0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                        if (have_ref) begin
                            dir  <= (conv_nout > pos);
                            skip <= is_skip;
                            if (is_skip)
                                err_cnt <= err_sat;
                        end else begin
                            dir  <= 1'b0;
                            skip <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                FAULT: begin
                    if (clr) begin
                        fault <= 1'b0;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed last so clr overrides any increment made above.
            if (clr) begin
                err_cnt <= '0;
                consec  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_gray_pos_tracker.sv
// tb_gray_pos_tracker
//   Directed bench for gray_pos_tracker with STABLE_CYCLES=4, ERR_LIMIT=3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_gray_pos_tracker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] nin = 4'b0000;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] pos_out;
    logic       dir;
    logic       skip;
    logic [3:0] err_cnt;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    int         ev_count;
    logic [3:0] ev_pos;
    logic       ev_dir;
    logic       ev_skip;

    gray_pos_tracker #(.STABLE_CYCLES(4), .ERR_LIMIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .nin       (nin),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .pos_out   (pos_out),
        .dir       (dir),
        .skip      (skip),
        .err_cnt   (err_cnt),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances n edges, counting cycles with out_valid and capturing the
    // fields of the first such cycle.
    task automatic run_cycles(input int n);
        ev_count = 0;
        ev_pos   = 4'hx;
        ev_dir   = 1'bx;
        ev_skip  = 1'bx;
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                if (ev_count == 0) begin
                    ev_pos  = pos_out;
                    ev_dir  = dir;
                    ev_skip = skip;
                end
                ev_count++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; nin = 4'b0000; out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (pos_out !== 4'd0) begin n_err++; $display("FAIL reset_pos: got %0d expected 0", pos_out); end
        n_cmp++; if (dir !== 1'b0) begin n_err++; $display("FAIL reset_dir: got %b expected 0", dir); end
        n_cmp++; if (skip !== 1'b0) begin n_err++; $display("FAIL reset_skip: got %b expected 0", skip); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b expected 0", fault); end
    endtask

    task automatic test_settle();
        int edges;
        edges = 0;
        rst = 1'b0; en = 1'b1;
        while (edges < 20 && out_valid !== 1'b1) begin
            tick();
            edges++;
        end
        n_cmp++; if (edges !== 5) begin n_err++; $display("FAIL settle_latency: got %0d edges expected 5", edges); end
        n_cmp++; if (pos_out !== 4'd0) begin n_err++; $display("FAIL settle_pos: got %0d expected 0", pos_out); end
        n_cmp++; if (dir !== 1'b0) begin n_err++; $display("FAIL settle_dir: got %b expected 0", dir); end
        n_cmp++; if (skip !== 1'b0) begin n_err++; $display("FAIL settle_skip: got %b expected 0", skip); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL settle_accept: got %b expected 0", out_valid); end
        run_cycles(20);
        n_cmp++; if (ev_count !== 0) begin n_err++; $display("FAIL settle_quiet: got %0d events expected 0", ev_count); end
    endtask

    task automatic test_steps();
        logic [3:0] codes [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0011};
        logic [3:0] exp_pos [4] = '{4'd1, 4'd2, 4'd3, 4'd2};
        logic       exp_dir [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nin = codes[i];
            run_cycles(8);
            n_cmp++; if (ev_count !== 1) begin n_err++; $display("FAIL step%0d_count: got %0d expected 1", i, ev_count); end
            n_cmp++; if (ev_pos !== exp_pos[i]) begin n_err++; $display("FAIL step%0d_pos: got %0d expected %0d", i, ev_pos, exp_pos[i]); end
            n_cmp++; if (ev_dir !== exp_dir[i]) begin n_err++; $display("FAIL step%0d_dir: got %b expected %b", i, ev_dir, exp_dir[i]); end
            n_cmp++; if (ev_skip !== 1'b0) begin n_err++; $display("FAIL step%0d_skip: got %b expected 0", i, ev_skip); end
        end
        n_cmp++; if (err_cnt !== 4'd0) begin n_err++; $display("FAIL steps_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_glitch_skip();
        rst = 1'b1; nin = 4'b0000; out_ready = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1;
        run_cycles(8);
        n_cmp++; if (ev_count !== 1 || ev_pos !== 4'd0) begin n_err++; $display("FAIL glitch_base: got %0d events pos %0d expected 1 event pos 0", ev_count, ev_pos); end
        nin = 4'b0001;
        tick(); tick();
        nin = 4'b0000;
        run_cycles(15);
        n_cmp++; if (ev_count !== 0) begin n_err++; $display("FAIL glitch_none: got %0d events expected 0", ev_count); end
        nin = 4'b0110;
        run_cycles(8);
        n_cmp++; if (ev_count !== 1) begin n_err++; $display("FAIL skip_count: got %0d expected 1", ev_count); end
        n_cmp++; if (ev_pos !== 4'd4) begin n_err++; $display("FAIL skip_pos: got %0d expected 4", ev_pos); end
        n_cmp++; if (ev_dir !== 1'b1) begin n_err++; $display("FAIL skip_dir: got %b expected 1", ev_dir); end
        n_cmp++; if (ev_skip !== 1'b1) begin n_err++; $display("FAIL skip_flag: got %b expected 1", ev_skip); end
        n_cmp++; if (err_cnt !== 4'd1) begin n_err++; $display("FAIL skip_err: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_fault();
        logic [3:0] bad [3] = '{4'b1111, 4'b1000, 4'b1001};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (err_cnt !== 4'd0) begin n_err++; $display("FAIL fault_preclr: got %0d expected 0", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            nin = bad[i];
            run_cycles(8);
            n_cmp++; if (ev_count !== 0) begin n_err++; $display("FAIL illegal%0d_event: got %0d expected 0", i, ev_count); end
            n_cmp++; if (err_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL illegal%0d_err: got %0d expected %0d", i, err_cnt, i + 1); end
            n_cmp++; if (fault !== (i == 2)) begin n_err++; $display("FAIL illegal%0d_fault: got %b expected %b", i, fault, (i == 2)); end
        end
        nin = 4'b0001;
        run_cycles(8);
        n_cmp++; if (ev_count !== 0 || fault !== 1'b1) begin n_err++; $display("FAIL fault_ignore: got %0d events fault %b expected 0 events fault 1", ev_count, fault); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clr: got %b expected 0", fault); end
        n_cmp++; if (err_cnt !== 4'd0) begin n_err++; $display("FAIL fault_clr_err: got %0d expected 0", err_cnt); end
        run_cycles(4);
        // Previous position was 4, so 1 is a downward skip.
        n_cmp++; if (ev_count !== 1 || ev_pos !== 4'd1) begin n_err++; $display("FAIL fault_resume: got %0d events pos %0d expected 1 event pos 1", ev_count, ev_pos); end
        n_cmp++; if (ev_dir !== 1'b0 || ev_skip !== 1'b1) begin n_err++; $display("FAIL fault_resume_flags: got dir %b skip %b expected dir 0 skip 1", ev_dir, ev_skip); end
        n_cmp++; if (err_cnt !== 4'd1) begin n_err++; $display("FAIL fault_resume_err: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_backpressure();
        int bad_cycles;
        bad_cycles = 0;
        out_ready = 1'b0;
        nin = 4'b0000;
        run_cycles(8);
        n_cmp++; if (ev_count < 1 || ev_pos !== 4'd0 || ev_dir !== 1'b0 || ev_skip !== 1'b0) begin n_err++; $display("FAIL bp_first: got %0d cycles pos %0d dir %b skip %b expected pos 0 dir 0 skip 0", ev_count, ev_pos, ev_dir, ev_skip); end
        nin = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b1 || pos_out !== 4'd0) bad_cycles++;
        end
        n_cmp++; if (bad_cycles !== 0) begin n_err++; $display("FAIL bp_frozen: got %0d changed cycles expected 0", bad_cycles); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept: got %b expected 0", out_valid); end
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b1 || pos_out !== 4'd1) begin n_err++; $display("FAIL bp_next: got valid %b pos %0d expected valid 1 pos 1", out_valid, pos_out); end
        n_cmp++; if (dir !== 1'b1 || skip !== 1'b0) begin n_err++; $display("FAIL bp_next_flags: got dir %b skip %b expected dir 1 skip 0", dir, skip); end
    endtask

    task automatic test_reset_in_hold();
        rst = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || pos_out !== 4'd0 || dir !== 1'b0 || skip !== 1'b0 || err_cnt !== 4'd0 || fault !== 1'b0)
        begin n_err++; $display("FAIL hold_rst: got valid %b pos %0d dir %b skip %b err %0d fault %b expected all 0", out_valid, pos_out, dir, skip, err_cnt, fault); end
        rst = 1'b0; en = 1'b1; out_ready = 1'b1; nin = 4'b0001;
        run_cycles(12);
        n_cmp++; if (ev_count !== 1 || ev_pos !== 4'd1) begin n_err++; $display("FAIL hold_rst_event: got %0d events pos %0d expected 1 event pos 1", ev_count, ev_pos); end
        n_cmp++; if (ev_dir !== 1'b0 || ev_skip !== 1'b0) begin n_err++; $display("FAIL hold_rst_flags: got dir %b skip %b expected dir 0 skip 0", ev_dir, ev_skip); end
    endtask

    initial begin
        #1;
        test_reset();
        test_settle();
        test_steps();
        test_glitch_skip();
        test_fault();
        test_backpressure();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
